dmem_responder: RTL and testbench

//  Responder end of the core's data-memory interface: a word-organised data RAM behind a valid/ready request/response handshake.

---
 rtl/dmem_pkg.sv | 26 ++
 rtl/dmem_responder_if.sv | 23 ++
 rtl/dmem_store_lanes.sv | 39 +++
 rtl/dmem_responder.sv | 119 +++++++++++
 tb/tb_dmem_responder.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// Shared types and funct3 encodings for the data-memory responder.
// Also holds the funct3 legality check used on each latched request.
package dmem_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_RESP
    } dmem_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Unsigned load encodings have no store meaning; the remaining codes are reserved.
    function automatic logic f3_illegal(input logic [2:0] funct3, input logic we);
        case (funct3)
            F3_B, F3_H, F3_W: f3_illegal = 1'b0;
            F3_BU, F3_HU:     f3_illegal = we;
            default:          f3_illegal = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response handshake between the core (master) and the data RAM (slave).
interface dmem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_funct3;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_funct3, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_funct3, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_store_lanes.sv
// Byte-lane decode: funct3 and the low address bits give byte enables,
// lane-replicated store data and an alignment fault flag.
module dmem_store_lanes
    import dmem_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_al,
    output logic        misalign
);

    always_comb begin
        // NOTE: every output gets a default first so no path through the case leaves a latch.
        be       = 4'b0000;
        wdata_al = wdata;
        misalign = 1'b0;
        case (funct3)
            F3_B, F3_BU: begin
                be       = 4'b0001 << addr_lo;
                wdata_al = {4{wdata[7:0]}};
            end
            F3_H, F3_HU: begin
                be       = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_al = {2{wdata[15:0]}};
                misalign = addr_lo[0];
            end
            F3_W: begin
                be       = 4'b1111;
                misalign = (addr_lo != 2'b00);
            end
            default: begin
                be = 4'b0000;
            end
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Word-organised data RAM behind a valid/ready request/response handshake.
// One request in flight: accept, WAIT_CYCLES of latency, access, then hold the response.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic            clk,
    input  logic            reset,
    dmem_responder_if.slave bus
);

    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

    dmem_state_t state;
    logic [CW-1:0] cnt;
    logic          req_ready;
    logic          rsp_valid;
    logic [31:0]   rsp_rdata;
    logic          rsp_err;

    logic          lat_we;
    logic [31:0]   lat_addr;
    logic [31:0]   lat_wdata;
    logic [2:0]    lat_f3;

    logic [31:0]   mem [DEPTH_WORDS];

    logic [3:0]    be;
    logic [31:0]   wdata_al;
    logic          misalign;
    logic          out_of_range;
    logic          err;
    logic          commit;
    logic [AW-1:0] idx;

    dmem_store_lanes u_lanes (
        .funct3   (lat_f3),
        .addr_lo  (lat_addr[1:0]),
        .wdata    (lat_wdata),
        .be       (be),
        .wdata_al (wdata_al),
        .misalign (misalign)
    );

    assign idx          = lat_addr[AW+1:2];
    assign out_of_range = (lat_addr[31:2] >= 30'(DEPTH_WORDS));
    assign err          = misalign | out_of_range | f3_illegal(lat_f3, lat_we);
    assign commit       = (state == S_ACCESS) && (cnt == '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_f3    <= '0;
        end else begin
            // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
            case (state)
                S_IDLE: begin
                    if (bus.req_valid && req_ready) begin
                        lat_we    <= bus.req_we;
                        lat_addr  <= bus.req_addr;
                        lat_wdata <= bus.req_wdata;
                        lat_f3    <= bus.req_funct3;
                        cnt       <= CW'(WAIT_CYCLES);
                        req_ready <= 1'b0;
                        state     <= S_ACCESS;
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                S_ACCESS: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        rsp_valid <= 1'b1;
                        rsp_err   <= err;
                        rsp_rdata <= (!lat_we && !err) ? mem[idx] : 32'h0;
                        state     <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // NOTE: the RAM array has no reset; contents survive reset and start undefined.
    always_ff @(posedge clk) begin
        if (commit && lat_we && !err) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[idx][8*i +: 8] <= wdata_al[8*i +: 8];
            end
        end
    end

    assign bus.req_ready = req_ready;
    assign bus.rsp_valid = rsp_valid;
    assign bus.rsp_rdata = rsp_rdata;
    assign bus.rsp_err   = rsp_err;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench: two responders (WAIT_CYCLES=2 and 0); stimulus pushes expected
// responses, a negedge monitor pops and compares data, error flag and latency.
module tb_dmem_responder;
    import dmem_pkg::*;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          acc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    logic [1:0]  rst_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_we;
    logic [1:0]  rsp_ready;
    logic [31:0] req_addr  [2];
    logic [31:0] req_wdata [2];
    logic [2:0]  req_f3    [2];
    wire         req_ready [2];
    wire         rsp_valid [2];
    wire         rsp_err   [2];
    wire  [31:0] rsp_rdata [2];

    exp_t q0[$];
    exp_t q1[$];
    bit   seen [2];

    dmem_responder_if bus_w2 ();
    dmem_responder_if bus_w0 ();

    assign bus_w2.req_valid  = req_valid[0];
    assign bus_w2.req_we     = req_we[0];
    assign bus_w2.req_addr   = req_addr[0];
    assign bus_w2.req_wdata  = req_wdata[0];
    assign bus_w2.req_funct3 = req_f3[0];
    assign bus_w2.rsp_ready  = rsp_ready[0];
    assign req_ready[0] = bus_w2.req_ready;
    assign rsp_valid[0] = bus_w2.rsp_valid;
    assign rsp_err[0]   = bus_w2.rsp_err;
    assign rsp_rdata[0] = bus_w2.rsp_rdata;

    assign bus_w0.req_valid  = req_valid[1];
    assign bus_w0.req_we     = req_we[1];
    assign bus_w0.req_addr   = req_addr[1];
    assign bus_w0.req_wdata  = req_wdata[1];
    assign bus_w0.req_funct3 = req_f3[1];
    assign bus_w0.rsp_ready  = rsp_ready[1];
    assign req_ready[1] = bus_w0.req_ready;
    assign rsp_valid[1] = bus_w0.rsp_valid;
    assign rsp_err[1]   = bus_w0.rsp_err;
    assign rsp_rdata[1] = bus_w0.rsp_rdata;

    dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(2)) u_w2 (
        .clk(clk), .reset(rst_n[0]), .bus(bus_w2)
    );
    dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) u_w0 (
        .clk(clk), .reset(rst_n[1]), .bus(bus_w0)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: compare each new response against the head of its DUT's queue.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!rst_n[d] || !rsp_valid[d]) begin
                seen[d] = 1'b0;
            end else if (!seen[d]) begin
                exp_t e;
                bit   ok;
                seen[d] = 1'b1;
                ok = 1'b0;
                if (d == 0 && q0.size() > 0) begin e = q0.pop_front(); ok = 1'b1; end
                if (d == 1 && q1.size() > 0) begin e = q1.pop_front(); ok = 1'b1; end
                if (!ok) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_rsp dut%0d: response with empty scoreboard", d);
                end else begin
                    check($sformatf("rdata dut%0d", d), rsp_rdata[d], e.rdata);
                    check($sformatf("err dut%0d", d), {31'b0, rsp_err[d]}, {31'b0, e.err});
                    check($sformatf("latency dut%0d", d), 32'(cyc - e.acc), (d == 0) ? 32'd3 : 32'd1);
                end
            end
        end
    end

    task automatic issue(input int d, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_rdata, input logic exp_err, input bit push);
        exp_t e;
        bit   got;
        got = 1'b0;
        @(negedge clk);
        req_we[d]    = we;
        req_f3[d]    = f3;
        req_addr[d]  = addr;
        req_wdata[d] = wdata;
        req_valid[d] = 1'b1;
        for (int n = 0; n < 100 && !got; n++) begin
            if (req_ready[d]) got = 1'b1;
            @(negedge clk);
        end
        req_valid[d] = 1'b0;
        req_addr[d]  = 32'hFFFF_FFFF;
        req_wdata[d] = 32'h5A5A_5A5A;
        req_we[d]    = 1'b1;
        if (!got) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout dut%0d addr %h", d, addr);
        end else if (push) begin
            e.rdata = exp_rdata;
            e.err   = exp_err;
            e.acc   = cyc;
            if (d == 0) q0.push_back(e);
            else        q1.push_back(e);
        end
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        for (int n = 0; n < 200 && !done; n++) begin
            @(negedge clk);
            if (q0.size() == 0 && q1.size() == 0 && !rsp_valid[0] && !rsp_valid[1]) done = 1'b1;
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: q0=%0d q1=%0d", q0.size(), q1.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit got;
        rst_n     = 2'b00;
        req_valid = 2'b00;
        req_we    = 2'b00;
        rsp_ready = 2'b11;
        for (int d = 0; d < 2; d++) begin
            req_addr[d]  = '0;
            req_wdata[d] = '0;
            req_f3[d]    = F3_W;
        end
        #1;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("reset rsp_valid dut%0d", d), {31'b0, rsp_valid[d]}, 32'd0);
            check($sformatf("reset req_ready dut%0d", d), {31'b0, req_ready[d]}, 32'd0);
            check($sformatf("reset rsp_rdata dut%0d", d), rsp_rdata[d], 32'd0);
            check($sformatf("reset rsp_err dut%0d", d), {31'b0, rsp_err[d]}, 32'd0);
        end
        repeat (2) @(negedge clk);
        rst_n = 2'b11;

        // Word store then load
        issue(0, 1'b1, F3_W, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 1'b1);
        issue(0, 1'b0, F3_W, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 1'b1);

        // Byte and half lanes merge into an existing word
        issue(0, 1'b1, F3_W, 32'h20, 32'h11223344, 32'h0, 1'b0, 1'b1);
        issue(0, 1'b1, F3_B, 32'h21, 32'h123456AA, 32'h0, 1'b0, 1'b1);
        issue(0, 1'b1, F3_H, 32'h22, 32'h5555BEEF, 32'h0, 1'b0, 1'b1);
        issue(0, 1'b0, F3_W, 32'h20, 32'h0, 32'hBEEFAA44, 1'b0, 1'b1);

        // Error cases leave memory untouched; sub-word loads return the whole word
        issue(0, 1'b1, F3_W, 32'h30, 32'h0BADF00D, 32'h0, 1'b0, 1'b1);
        issue(0, 1'b1, F3_H, 32'h31, 32'hFFFFFFFF, 32'h0, 1'b1, 1'b1);
        issue(0, 1'b1, F3_W, 32'h32, 32'hFFFFFFFF, 32'h0, 1'b1, 1'b1);
        issue(0, 1'b0, F3_W, 32'd4096, 32'h0, 32'h0, 1'b1, 1'b1);
        issue(0, 1'b0, 3'b011, 32'h30, 32'h0, 32'h0, 1'b1, 1'b1);
        issue(0, 1'b1, 3'b110, 32'h30, 32'hFFFFFFFF, 32'h0, 1'b1, 1'b1);
        issue(0, 1'b0, F3_W, 32'h30, 32'h0, 32'h0BADF00D, 1'b0, 1'b1);
        issue(0, 1'b0, F3_HU, 32'h32, 32'h0, 32'h0BADF00D, 1'b0, 1'b1);
        issue(0, 1'b0, F3_B, 32'h33, 32'h0, 32'h0BADF00D, 1'b0, 1'b1);
        issue(0, 1'b0, F3_H, 32'h33, 32'h0, 32'h0, 1'b1, 1'b1);
        issue(0, 1'b1, F3_W, 32'd4092, 32'hA5A5C3C3, 32'h0, 1'b0, 1'b1);
        issue(0, 1'b0, F3_W, 32'd4092, 32'h0, 32'hA5A5C3C3, 1'b0, 1'b1);
        drain();

        // Backpressure: response held stable while rsp_ready is low
        rsp_ready[0] = 1'b0;
        issue(0, 1'b0, F3_W, 32'h20, 32'h0, 32'hBEEFAA44, 1'b0, 1'b1);
        got = 1'b0;
        for (int n = 0; n < 20 && !got; n++) begin
            if (rsp_valid[0]) got = 1'b1;
            else @(negedge clk);
        end
        if (!got) begin
            n_checks++;
            n_fail++;
            $display("FAIL bp_wait: rsp_valid never rose");
        end
        for (int n = 0; n < 5; n++) begin
            check("bp rsp_valid", {31'b0, rsp_valid[0]}, 32'd1);
            check("bp rsp_rdata", rsp_rdata[0], 32'hBEEFAA44);
            check("bp req_ready", {31'b0, req_ready[0]}, 32'd0);
            @(negedge clk);
        end
        rsp_ready[0] = 1'b1;
        @(negedge clk);
        check("bp release rsp_valid", {31'b0, rsp_valid[0]}, 32'd0);
        check("bp release req_ready", {31'b0, req_ready[0]}, 32'd1);

        // Zero wait cycles; unsigned funct3 on a store is rejected
        issue(1, 1'b1, F3_W, 32'h40, 32'hCAFEF00D, 32'h0, 1'b0, 1'b1);
        issue(1, 1'b0, F3_W, 32'h40, 32'h0, 32'hCAFEF00D, 1'b0, 1'b1);
        issue(1, 1'b1, F3_BU, 32'h40, 32'h11111111, 32'h0, 1'b1, 1'b1);
        issue(1, 1'b1, F3_HU, 32'h42, 32'h22222222, 32'h0, 1'b1, 1'b1);
        issue(1, 1'b0, F3_W, 32'h40, 32'h0, 32'hCAFEF00D, 1'b0, 1'b1);
        issue(1, 1'b1, F3_B, 32'h43, 32'h00000077, 32'h0, 1'b0, 1'b1);
        issue(1, 1'b0, F3_W, 32'h40, 32'h0, 32'h77FEF00D, 1'b0, 1'b1);
        drain();

        // Reset during a store in ACCESS (cnt=1) abandons the write
        issue(0, 1'b1, F3_W, 32'h50, 32'h12345678, 32'h0, 1'b0, 1'b1);
        issue(0, 1'b0, F3_W, 32'h50, 32'h0, 32'h12345678, 1'b0, 1'b1);
        drain();
        issue(0, 1'b1, F3_W, 32'h50, 32'h99999999, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n[0] = 1'b0;
        #1;
        check("midrst rsp_valid", {31'b0, rsp_valid[0]}, 32'd0);
        check("midrst req_ready", {31'b0, req_ready[0]}, 32'd0);
        check("midrst rsp_rdata", rsp_rdata[0], 32'd0);
        check("midrst rsp_err", {31'b0, rsp_err[0]}, 32'd0);
        repeat (3) @(negedge clk);
        check("midrst held rsp_valid", {31'b0, rsp_valid[0]}, 32'd0);
        rst_n[0] = 1'b1;
        issue(0, 1'b0, F3_W, 32'h50, 32'h0, 32'h12345678, 1'b0, 1'b1);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
